// File: rtl/aes_ct_packer.sv
// Packs the aes_api ciphertext strobe stream into framed 128-bit packets:
// two bypass-text header beats, then the packet's blocks; drops on overflow.
module aes_ct_packer #(
  parameter int DEPTH     = 8,
  parameter int HDR_DEPTH = 2,
  parameter int BYPASS_W  = 161
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_cp_ready,
  input  logic [127:0]          i_cipher_text,
  input  logic                  i_last,
  input  logic [BYPASS_W-1:0]   i_bypass_text,
  output logic [127:0]          o_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_sof,
  output logic                  o_eof,
  output logic                  o_overflow,
  output logic [$clog2(DEPTH):0] o_level
);
  localparam int AW = $clog2(DEPTH);
  localparam int HW = $clog2(HDR_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {IDLE, HDR0, HDR1, DATA} state_t;
  state_t state, state_nxt;

  logic [128:0]         mem  [DEPTH];
  logic [BYPASS_W-1:0]  hmem [HDR_DEPTH];
  logic [AW-1:0]        wptr, rptr;
  logic [LW-1:0]        cnt;
  logic [HW-1:0]        hwptr, hrptr;
  logic [HW:0]          hcnt;
  logic                 in_pkt, drop, overflow;
  logic                 in_pkt_nxt, drop_nxt, ovf_set;
  logic                 blk_push, blk_pop, blk_mark, hdr_push, hdr_pop;
  logic                 blk_room, hdr_room, blk_empty, hdr_empty;
  logic [128:0]         blk_head;
  logic [BYPASS_W-1:0]  hdr_head;
  logic [127:0]         hdr_hi;

  assign blk_empty = (cnt == '0);
  assign hdr_empty = (hcnt == '0);
  // Fullness is judged after a same-cycle pop.
  assign blk_room  = (cnt != LW'(DEPTH)) || blk_pop;
  assign hdr_room  = (hcnt != (HW+1)'(HDR_DEPTH)) || hdr_pop;
  assign blk_head  = mem[rptr];
  assign hdr_head  = hmem[hrptr];

  always_comb begin
    hdr_hi = '0;
    hdr_hi[BYPASS_W-129:0] = hdr_head[BYPASS_W-1:128];
  end

  // Input side: accept, or enter drop mode and close the open packet.
  always_comb begin
    blk_push   = 1'b0;
    hdr_push   = 1'b0;
    blk_mark   = 1'b0;
    ovf_set    = 1'b0;
    in_pkt_nxt = in_pkt;
    drop_nxt   = drop;
    if (i_cp_ready) begin
      if (drop) begin
        drop_nxt = !i_last;
      end else if (!blk_room || (!in_pkt && !hdr_room)) begin
        ovf_set    = 1'b1;
        drop_nxt   = !i_last;
        in_pkt_nxt = 1'b0;
        blk_mark   = in_pkt;
      end else begin
        blk_push   = 1'b1;
        hdr_push   = !in_pkt;
        in_pkt_nxt = !i_last;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    o_valid   = 1'b0;
    o_sof     = 1'b0;
    o_eof     = 1'b0;
    o_data    = '0;
    hdr_pop   = 1'b0;
    blk_pop   = 1'b0;
    case (state)
      IDLE: if (!hdr_empty && !blk_empty) state_nxt = HDR0;
      HDR0: begin
        o_valid = 1'b1;
        o_sof   = 1'b1;
        o_data  = hdr_head[127:0];
        if (i_ready) state_nxt = HDR1;
      end
      HDR1: begin
        o_valid = 1'b1;
        o_data  = hdr_hi;
        if (i_ready) begin
          hdr_pop   = 1'b1;
          state_nxt = DATA;
        end
      end
      DATA: if (!blk_empty) begin
        o_valid = 1'b1;
        o_data  = blk_head[127:0];
        o_eof   = blk_head[128];
        if (i_ready) begin
          blk_pop = 1'b1;
          if (blk_head[128]) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      wptr     <= '0;
      rptr     <= '0;
      cnt      <= '0;
      hwptr    <= '0;
      hrptr    <= '0;
      hcnt     <= '0;
      in_pkt   <= 1'b0;
      drop     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state  <= state_nxt;
      in_pkt <= in_pkt_nxt;
      drop   <= drop_nxt;
      if (ovf_set)  overflow <= 1'b1;
      if (blk_push) wptr  <= wptr + AW'(1);
      if (blk_pop)  rptr  <= rptr + AW'(1);
      if (hdr_push) hwptr <= hwptr + HW'(1);
      if (hdr_pop)  hrptr <= hrptr + HW'(1);
      if (blk_push && !blk_pop)      cnt <= cnt + LW'(1);
      else if (!blk_push && blk_pop) cnt <= cnt - LW'(1);
      if (hdr_push && !hdr_pop)      hcnt <= hcnt + (HW+1)'(1);
      else if (!hdr_push && hdr_pop) hcnt <= hcnt - (HW+1)'(1);
    end
  end

  // Storage needs no reset; outputs are gated by FSM state and counts.
  always_ff @(posedge clk) begin
    if (blk_push) mem[wptr] <= {i_last, i_cipher_text};
    if (blk_mark) mem[wptr - AW'(1)][128] <= 1'b1;
    if (hdr_push) hmem[hwptr] <= i_bypass_text;
  end

  assign o_level    = cnt;
  assign o_overflow = overflow;

endmodule

// File: tb/tb_aes_ct_packer.sv
// Randomized + directed bench for aes_ct_packer against a packet-level
// scoreboard model (flat expected-beat queue, occupancy counters).
module tb_aes_ct_packer;
  localparam int DEPTH = 8, HDR_DEPTH = 2, BW = 161;

  logic           clk = 1'b0, reset_n = 1'b0;
  logic           i_cp_ready = 1'b0, i_last = 1'b0, i_ready = 1'b0;
  logic [127:0]   i_cipher_text = '0;
  logic [BW-1:0]  i_bypass_text = '0;
  logic [127:0]   o_data;
  logic           o_valid, o_sof, o_eof, o_overflow;
  logic [3:0]     o_level;

  aes_ct_packer #(.DEPTH(DEPTH), .HDR_DEPTH(HDR_DEPTH), .BYPASS_W(BW)) dut (
    .clk(clk), .reset_n(reset_n), .i_cp_ready(i_cp_ready),
    .i_cipher_text(i_cipher_text), .i_last(i_last), .i_bypass_text(i_bypass_text),
    .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready), .o_sof(o_sof),
    .o_eof(o_eof), .o_overflow(o_overflow), .o_level(o_level)
  );

  always #5 clk = ~clk;

  typedef struct { logic [127:0] d; logic sof; logic eof; int kind; } beat_t;
  beat_t exp_q[$];
  int n_chk = 0, n_fail = 0;
  int m_blk = 0, m_hdr = 0;
  bit m_in_pkt = 0, m_drop = 0, m_ovf = 0;
  bit stalled = 0;
  logic [129:0] held;
  bit s_valid, s_sof, s_ovf;
  int s_kind;
  logic [3:0] s_level;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [BW-1:0] rnd_byp();
    logic [191:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return t[BW-1:0];
  endfunction

  // Reference: every accepted block lands in the beat stream in arrival order,
  // preceded by its packet's two header beats when it opens a packet.
  task automatic model_in(input bit cp, input logic [127:0] ct, input bit last,
                          input logic [BW-1:0] byp, input bit pop_blk, input bit pop_hdr);
    bit first, blk_ok, hdr_ok;
    logic [BW-1:0] hi;
    beat_t b;
    if (cp) begin
      if (m_drop) m_drop = !last;
      else begin
        first  = !m_in_pkt;
        blk_ok = (m_blk < DEPTH) || pop_blk;
        hdr_ok = (m_hdr < HDR_DEPTH) || pop_hdr;
        if (!blk_ok || (first && !hdr_ok)) begin
          m_ovf = 1; m_drop = !last; m_in_pkt = 0;
          if (!first && exp_q.size() > 0) begin
            b = exp_q.pop_back(); b.eof = 1'b1; exp_q.push_back(b);
          end
        end else begin
          if (first) begin
            hi = byp >> 128;
            exp_q.push_back('{byp[127:0], 1'b1, 1'b0, 0});
            exp_q.push_back('{hi[127:0], 1'b0, 1'b0, 1});
            m_hdr++;
          end
          exp_q.push_back('{ct, 1'b0, last, 2});
          m_blk++;
          m_in_pkt = !last;
        end
      end
    end
    if (pop_blk) m_blk--;
    if (pop_hdr) m_hdr--;
  endtask

  task automatic step(input bit cp, input logic [127:0] ct, input bit last,
                      input logic [BW-1:0] byp, input bit rdy);
    bit pb, ph;
    beat_t b;
    @(negedge clk);
    i_cp_ready = cp; i_cipher_text = ct; i_last = last; i_bypass_text = byp; i_ready = rdy;
    #1;
    s_valid = o_valid; s_sof = o_sof; s_level = o_level; s_ovf = o_overflow; s_kind = -1;
    chk("level", o_level, m_blk);
    chk("overflow", o_overflow, m_ovf);
    if (stalled) chk("hold", {o_valid, o_sof, o_eof, o_data}, {1'b1, held});
    stalled = o_valid && !rdy;
    held = {o_sof, o_eof, o_data};
    pb = 0; ph = 0;
    if (o_valid && rdy) begin
      if (exp_q.size() == 0) chk("spurious_beat", o_valid, 0);
      else begin
        b = exp_q.pop_front();
        s_kind = b.kind;
        chk("beat", {o_sof, o_eof, o_data}, {b.sof, b.eof, b.d});
        pb = (b.kind == 2); ph = (b.kind == 1);
      end
    end
    model_in(cp, ct, last, byp, pb, ph);
  endtask

  task automatic idle(input bit rdy);
    step(0, rnd128(), 0, rnd_byp(), rdy);
  endtask

  task automatic drain(input int max);
    int n = 0;
    while (exp_q.size() > 0 && n < max) begin idle(1); n++; end
    chk("drain_empty", exp_q.size(), 0);
    idle(1);
    chk("drain_idle", s_valid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [BW-1:0] byp;
    repeat (3) @(negedge clk);
    chk("rst_valid", o_valid, 0);
    chk("rst_data", o_data, 0);
    chk("rst_flags", {o_sof, o_eof, o_overflow}, 0);
    chk("rst_level", o_level, 0);
    reset_n = 1'b1;

    // single packet, 2-cycle spacing, latency
    byp = rnd_byp(); byp[15:0] = 16'hff00;
    step(1, rnd128(), 0, byp, 1);
    idle(1);                        chk("t1_lat_idle", s_valid, 0);
    step(1, rnd128(), 0, rnd_byp(), 1); chk("t1_lat_sof", {s_valid, s_sof}, 2'b11);
    idle(1);
    step(1, rnd128(), 1, rnd_byp(), 1); chk("t1_first_data", s_kind, 2);
    drain(30);

    // back-to-back packets
    byp = rnd_byp(); byp[15:0] = 16'hff00;
    step(1, rnd128(), 0, byp, 1);
    step(1, rnd128(), 1, rnd_byp(), 1);
    byp = rnd_byp(); byp[15:0] = 16'h0f01;
    step(1, rnd128(), 1, byp, 1);
    drain(30);
    chk("t2_no_ovf", s_ovf, 0);

    // backpressure in HDR1
    step(1, rnd128(), 0, rnd_byp(), 1);
    idle(1);
    idle(1);
    for (int i = 0; i < 10; i++) begin
      if (i < 3) step(1, rnd128(), i == 2, rnd_byp(), 0);
      else idle(0);
    end
    chk("t3_level", s_level, 4);
    idle(1);
    for (int i = 0; i < 4; i++) begin idle(1); chk("t3_stream", s_valid, 1); end
    drain(30);

    // header FIFO overflow
    for (int i = 0; i < 3; i++) step(1, rnd128(), 1, rnd_byp(), 0);
    idle(0);
    chk("t5_ovf", s_ovf, 1);
    chk("t5_level", s_level, 2);
    drain(30);

    // async reset while DATA holds 3 beats
    for (int i = 0; i < 3; i++) step(1, rnd128(), i == 2, rnd_byp(), 0);
    idle(1);
    idle(1);
    idle(0);
    chk("t6_pre_q", exp_q.size(), 3);
    chk("t6_pre_valid", s_valid, 1);
    @(posedge clk); #2;
    reset_n = 1'b0; i_cp_ready = 1'b0;
    #1;
    chk("t6_valid", o_valid, 0);
    chk("t6_level", o_level, 0);
    chk("t6_ovf", o_overflow, 0);
    exp_q.delete(); m_blk = 0; m_hdr = 0; m_in_pkt = 0; m_drop = 0; m_ovf = 0; stalled = 0;
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    step(1, rnd128(), 0, rnd_byp(), 1);
    step(1, rnd128(), 1, rnd_byp(), 1);
    drain(30);

    // block FIFO overflow
    for (int i = 1; i <= 10; i++) begin
      step(1, rnd128(), i == 10, rnd_byp(), 0);
      if (i == 9)  chk("t4_pre_ovf", s_ovf, 0);
      if (i == 10) begin chk("t4_ovf", s_ovf, 1); chk("t4_level", s_level, 8); end
    end
    drain(40);
    step(1, rnd128(), 0, rnd_byp(), 1);
    step(1, rnd128(), 1, rnd_byp(), 1);
    drain(30);

    // random traffic with random backpressure
    for (int p = 0; p < 40; p++) begin
      int len;
      len = $urandom_range(1, 4);
      for (int k = 0; k < len; k++) begin
        int gap;
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) idle($urandom_range(0, 3) != 0);
        step(1, rnd128(), k == len - 1, rnd_byp(), $urandom_range(0, 3) != 0);
      end
    end
    drain(400);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
